// File: rtl/aes_block_dma.sv
// Block DMA: reads 128-bit plaintext blocks over AXI4-Lite, passes each through an AES core
// and writes the ciphertext back. Defining AES_DMA_IRQ_EN adds a sticky irq output.
module aes_block_dma #(
    parameter int unsigned NBLK_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cfg_src,
    input  logic [31:0]       cfg_dst,
    input  logic [NBLK_W-1:0] cfg_nblocks,
    input  logic              cfg_start,
`ifdef AES_DMA_IRQ_EN
    output logic              irq,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [31:0]       m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [31:0]       m_axi_rdata,
    output logic              aes_in_valid,
    input  logic              aes_in_ready,
    output logic [127:0]      aes_in_data,
    input  logic              aes_out_valid,
    output logic              aes_out_ready,
    input  logic [127:0]      aes_out_data
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, AES_SEND, AES_WAIT, WR_XFER, WR_RESP, NEXT
    } state_t;

    state_t            state_q;
    logic [31:0]       src_q, dst_q;
    logic [NBLK_W-1:0] nblk_q, blk_q;
    logic [1:0]        word_q;
    logic [127:0]      blk_data_q;
    logic              busy_q, done_q, err_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              aes_in_valid_q, aes_out_ready_q;
    logic [31:0]       araddr_q, awaddr_q, wdata_q;

    function automatic logic [31:0] beat_addr(input logic [31:0]       base,
                                              input logic [NBLK_W-1:0] blk,
                                              input logic [1:0]        word);
        logic [31:0] off;
        off = (32'(blk) << 4) | (32'(word) << 2);
        return base + off;
    endfunction

    logic [1:0]        word_d;
    logic [NBLK_W-1:0] blk_d;
    logic [31:0]       rd_addr_d, wr_addr_d, nxt_rd_addr_d;
    logic              misaligned, cfg_bad, start_acc, done_d;
    logic              aw_pend_d, w_pend_d;

    always_comb begin
        word_d        = word_q + 2'd1;
        blk_d         = blk_q + NBLK_W'(1);
        rd_addr_d     = beat_addr(src_q, blk_q, word_d);
        wr_addr_d     = beat_addr(dst_q, blk_q, word_d);
        nxt_rd_addr_d = beat_addr(src_q, blk_d, 2'd0);
        misaligned    = (|cfg_src[1:0]) | (|cfg_dst[1:0]);
        cfg_bad       = misaligned | (cfg_nblocks == '0);
        start_acc     = (state_q == IDLE) & cfg_start;
        done_d        = (start_acc & cfg_bad) | ((state_q == NEXT) & (blk_d == nblk_q));
        // AW and W complete independently; the beat is finished once neither is still pending
        aw_pend_d     = m_axi_awvalid & ~m_axi_awready;
        w_pend_d      = m_axi_wvalid & ~m_axi_wready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            src_q           <= '0;
            dst_q           <= '0;
            nblk_q          <= '0;
            blk_q           <= '0;
            word_q          <= '0;
            blk_data_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
            aes_in_valid_q  <= 1'b0;
            aes_out_ready_q <= 1'b0;
            araddr_q        <= '0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
        end else begin
            done_q <= done_d;
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        src_q  <= cfg_src;
                        dst_q  <= cfg_dst;
                        nblk_q <= cfg_nblocks;
                        err_q  <= misaligned;
                        blk_q  <= '0;
                        word_q <= '0;
                        if (!cfg_bad) begin
                            busy_q    <= 1'b1;
                            arvalid_q <= 1'b1;
                            araddr_q  <= cfg_src;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        blk_data_q[{word_q, 5'd0} +: 32] <= m_axi_rdata;
                        rready_q <= 1'b0;
                        word_q   <= word_d;
                        if (word_q == 2'd3) begin
                            aes_in_valid_q <= 1'b1;
                            state_q        <= AES_SEND;
                        end else begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= rd_addr_d;
                            state_q   <= RD_ADDR;
                        end
                    end
                end
                AES_SEND: begin
                    if (aes_in_ready) begin
                        aes_in_valid_q  <= 1'b0;
                        aes_out_ready_q <= 1'b1;
                        state_q         <= AES_WAIT;
                    end
                end
                AES_WAIT: begin
                    if (aes_out_valid) begin
                        blk_data_q      <= aes_out_data;
                        aes_out_ready_q <= 1'b0;
                        awvalid_q       <= 1'b1;
                        wvalid_q        <= 1'b1;
                        awaddr_q        <= beat_addr(dst_q, blk_q, 2'd0);
                        wdata_q         <= aes_out_data[31:0];
                        state_q         <= WR_XFER;
                    end
                end
                WR_XFER: begin
                    if (m_axi_awready) awvalid_q <= 1'b0;
                    if (m_axi_wready)  wvalid_q  <= 1'b0;
                    if (!aw_pend_d && !w_pend_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        word_q   <= word_d;
                        if (word_q == 2'd3) begin
                            state_q <= NEXT;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= wr_addr_d;
                            wdata_q   <= blk_data_q[{word_d, 5'd0} +: 32];
                            state_q   <= WR_XFER;
                        end
                    end
                end
                NEXT: begin
                    blk_q <= blk_d;
                    if (blk_d == nblk_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= nxt_rd_addr_d;
                        state_q   <= RD_ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (reset)          irq_q <= 1'b0;
        else if (done_d)    irq_q <= 1'b1;
        else if (start_acc) irq_q <= 1'b0;
    end

    assign irq = irq_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'b1111;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;
    assign aes_in_valid  = aes_in_valid_q;
    assign aes_in_data   = blk_data_q;
    assign aes_out_ready = aes_out_ready_q;

endmodule
